// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit : program-counter unit for the MIPS core.
//
// Holds the fetch address. Each cycle it picks the next PC from one of:
// sequential, branch, jump, register jump, exception entry, or exception
// return. A two-state FSM (RUN/EXC) captures EPC on exception entry, and
// bad_addr on a misaligned jr. The FSM state is visible on in_handler.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   stall       : hold pc/epc/bad_addr/FSM this cycle (exc still redirects)
//   exc         : external exception request
//   eret        : return from exception (ignored in RUN)
//   br_taken    : conditional branch taken
//   br_offset   : sign-extended word offset of the branch
//   jump        : J-format jump
//   jump_index  : 26-bit J-format instruction index
//   jr          : jump to register
//   jr_addr     : register jump target
//   pc          : current fetch address
//   pc_plus4    : pc + 4 (combinational)
//   epc         : exception program counter
//   bad_addr    : last misaligned jr target
//   in_handler  : 1 while the FSM is in EXC
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int              WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc,
    input  logic             eret,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] bad_addr,
    output logic             in_handler
);

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } state_t;

    state_t           state;
    logic             addr_err;
    logic             do_eret;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] pc_next;

    assign pc_plus4    = pc + WIDTH'(4);
    assign br_target   = pc_plus4 + (br_offset << 2);
    assign jump_target = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};

    // Only exc outranks a misaligned jr; while stalled the check waits for
    // the cycle on which the jr actually issues.
    assign addr_err = jr && (jr_addr[1:0] != 2'b00) && !exc && !stall;

    // eret only means something inside the handler; in RUN it is ignored.
    assign do_eret  = eret && (state == EXC);

    always_comb begin
        pc_next = pc_plus4;
        if (exc)
            pc_next = EXC_VECTOR;      // exc redirects even when stalled
        else if (stall)
            pc_next = pc;
        else if (addr_err)
            pc_next = EXC_VECTOR;
        else if (do_eret)
            pc_next = epc;
        else if (jr)
            pc_next = jr_addr;
        else if (jump)
            pc_next = jump_target;
        else if (br_taken)
            pc_next = br_target;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_VECTOR;
            epc      <= '0;
            bad_addr <= '0;
            state    <= RUN;
        end else begin
            pc <= pc_next;
            if (exc) begin
                // Nested exceptions keep the original return address.
                if (state == RUN) begin
                    epc   <= pc;
                    state <= EXC;
                end
            end else if (!stall) begin
                if (addr_err) begin
                    bad_addr <= jr_addr;
                    if (state == RUN) begin
                        epc   <= pc;
                        state <= EXC;
                    end
                end else if (do_eret) begin
                    state <= RUN;
                end
            end
        end
    end

    assign in_handler = (state == EXC);

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit : directed self-checking bench for pc_unit (default parameters).
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         exc;
    logic         eret;
    logic         br_taken;
    logic [W-1:0] br_offset;
    logic         jump;
    logic [25:0]  jump_index;
    logic         jr;
    logic [W-1:0] jr_addr;
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] epc;
    logic [W-1:0] bad_addr;
    logic         in_handler;

    int n_cmp;
    int n_err;

    pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .exc        (exc),
        .eret       (eret),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .jump       (jump),
        .jump_index (jump_index),
        .jr         (jr),
        .jr_addr    (jr_addr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .epc        (epc),
        .bad_addr   (bad_addr),
        .in_handler (in_handler)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        stall      = 1'b0;
        exc        = 1'b0;
        eret       = 1'b0;
        br_taken   = 1'b0;
        br_offset  = '0;
        jump       = 1'b0;
        jump_index = '0;
        jr         = 1'b0;
        jr_addr    = '0;
    endtask

    // one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        rst = 1'b0;

        // reset state
        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_bad", bad_addr, 32'h0);
        check("rst_inh", {31'b0, in_handler}, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        #10 rst = 1'b1;               // released between edges

        // free running
        step(); check("seq_4", pc, 32'h4);
        step(); check("seq_8", pc, 32'h8);
        step(); check("seq_c", pc, 32'hC);
        check("seq_inh", {31'b0, in_handler}, 32'h0);
        step(); check("seq_10", pc, 32'h10);

        // branch backwards: 0x14 + (-2 << 2) = 0x0C
        br_taken = 1'b1; br_offset = 32'hFFFF_FFFE;
        step(); check("br_back", pc, 32'hC);
        clear_inputs();
        // jump: {0x0, 0x40, 00} = 0x100
        jump = 1'b1; jump_index = 26'h40;
        step(); check("jump", pc, 32'h100);
        clear_inputs();

        // aligned jr, then misaligned jr enters the handler
        jr = 1'b1; jr_addr = 32'h20;
        step(); check("jr_ok", pc, 32'h20);
        check("jr_ok_inh", {31'b0, in_handler}, 32'h0);
        jr_addr = 32'h42;
        step(); check("aerr_pc", pc, 32'h80);
        check("aerr_epc", epc, 32'h20);
        check("aerr_bad", bad_addr, 32'h42);
        check("aerr_inh", {31'b0, in_handler}, 32'h1);
        clear_inputs();
        eret = 1'b1;
        step(); check("eret_pc", pc, 32'h20);
        check("eret_inh", {31'b0, in_handler}, 32'h0);
        clear_inputs();

        // stall
        jr = 1'b1; jr_addr = 32'h30;
        step(); check("jr_30", pc, 32'h30);
        clear_inputs();
        stall = 1'b1;
        step(); check("stall1", pc, 32'h30);
        step(); check("stall2", pc, 32'h30);
        jr = 1'b1; jr_addr = 32'h43;  // misaligned jr held off by stall
        step(); check("stall_aerr_pc", pc, 32'h30);
        check("stall_aerr_inh", {31'b0, in_handler}, 32'h0);
        check("stall_aerr_bad", bad_addr, 32'h42);
        jr = 1'b0; jr_addr = '0;
        exc = 1'b1;                   // exc overrides stall
        step(); check("stall_exc_pc", pc, 32'h80);
        check("stall_exc_epc", epc, 32'h30);
        check("stall_exc_inh", {31'b0, in_handler}, 32'h1);
        clear_inputs();

        // nested exceptions inside the handler
        step(); check("h_seq", pc, 32'h84);
        exc = 1'b1;
        step(); check("nest_pc", pc, 32'h80);
        check("nest_epc", epc, 32'h30);
        eret = 1'b1;                  // exc + eret: exc wins
        step(); check("exc_eret_pc", pc, 32'h80);
        check("exc_eret_inh", {31'b0, in_handler}, 32'h1);
        clear_inputs();
        jr = 1'b1; jr_addr = 32'h55;  // nested address error
        step(); check("nest_aerr_pc", pc, 32'h80);
        check("nest_aerr_bad", bad_addr, 32'h55);
        check("nest_aerr_epc", epc, 32'h30);
        check("nest_aerr_inh", {31'b0, in_handler}, 32'h1);
        jr_addr = 32'h200;            // eret outranks an aligned jr
        eret = 1'b1;
        step(); check("eret_over_jr", pc, 32'h30);
        check("eret_over_jr_inh", {31'b0, in_handler}, 32'h0);
        clear_inputs();

        // eret in RUN is ignored
        eret = 1'b1;
        step(); check("eret_run", pc, 32'h34);
        check("eret_run_inh", {31'b0, in_handler}, 32'h0);
        clear_inputs();

        // priority: jr over jump and branch
        jr = 1'b1; jr_addr = 32'h400; jump = 1'b1; jump_index = 26'h10;
        br_taken = 1'b1; br_offset = 32'h5;
        step(); check("jr_over_jump", pc, 32'h400);
        jr = 1'b0;                    // jump over branch
        step(); check("jump_over_br", pc, 32'h40);
        jump = 1'b0;                  // branch: 0x44 + 0x14 = 0x58
        step(); check("br_fwd", pc, 32'h58);
        clear_inputs();

        // wrap at the top of the address space
        jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
        step(); check("jr_top", pc, 32'hFFFF_FFFC);
        clear_inputs();
        step(); check("wrap", pc, 32'h0);
        step(); check("post_wrap", pc, 32'h4);

        // asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_epc", epc, 32'h0);
        check("arst_bad", bad_addr, 32'h0);
        check("arst_inh", {31'b0, in_handler}, 32'h0);
        #1 rst = 1'b1;
        step(); check("post_rst", pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
